// File: rtl/d_e_pipe_reg.sv
// d_e_pipe_reg: D->E pipeline register with stall hold, bubble insert and Tnew decrement
module d_e_pipe_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [31:0]       D_instr,
  input  logic [31:0]       D_pc,
  input  logic [31:0]       D_rs_data,
  input  logic [31:0]       D_rt_data,
  input  logic [31:0]       D_ext,
  input  logic [4:0]        D_a3,
  input  logic [TNEW_W-1:0] D_tnew,
  output logic [31:0]       E_instr,
  output logic [31:0]       E_pc,
  output logic [31:0]       E_rs_data,
  output logic [31:0]       E_rt_data,
  output logic [31:0]       E_ext,
  output logic [4:0]        E_a3,
  output logic [TNEW_W-1:0] E_tnew,
  output logic              E_valid
);
  logic [31:0]       instr_q, pc_q, rs_q, rt_q, ext_q;
  logic [31:0]       instr_d, pc_d, rs_d, rt_d, ext_d;
  logic [4:0]        a3_q, a3_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d, tnew_dec;
  logic              valid_q, valid_d;
  always_comb begin
    tnew_dec = (D_tnew == '0) ? '0 : D_tnew - TNEW_W'(1);
    instr_d  = clr ? '0   : en ? D_instr   : instr_q;
    pc_d     = (clr || en) ? D_pc : pc_q;
    rs_d     = clr ? '0   : en ? D_rs_data : rs_q;
    rt_d     = clr ? '0   : en ? D_rt_data : rt_q;
    ext_d    = clr ? '0   : en ? D_ext     : ext_q;
    a3_d     = clr ? '0   : en ? D_a3      : a3_q;
    tnew_d   = clr ? '0   : en ? tnew_dec  : tnew_q;
    valid_d  = clr ? 1'b0 : en ? 1'b1      : valid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= PC_RESET;
      rs_q    <= '0;
      rt_q    <= '0;
      ext_q   <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      ext_q   <= ext_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
      valid_q <= valid_d;
    end
  end
  assign E_instr   = instr_q;
  assign E_pc      = pc_q;
  assign E_rs_data = rs_q;
  assign E_rt_data = rt_q;
  assign E_ext     = ext_q;
  assign E_a3      = a3_q;
  assign E_tnew    = tnew_q;
  assign E_valid   = valid_q;
endmodule

// File: tb/tb_d_e_pipe_reg.sv
// tb_d_e_pipe_reg: directed self-checking bench for d_e_pipe_reg
module tb_d_e_pipe_reg;
  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [31:0] D_instr, D_pc, D_rs_data, D_rt_data, D_ext;
  logic [4:0]  D_a3;
  logic [1:0]  D_tnew;
  logic [31:0] E_instr, E_pc, E_rs_data, E_rt_data, E_ext;
  logic [4:0]  E_a3;
  logic [1:0]  E_tnew;
  logic        E_valid;
  int          vecs = 0;
  int          errs = 0;
  d_e_pipe_reg dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .D_instr(D_instr), .D_pc(D_pc), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .D_ext(D_ext), .D_a3(D_a3), .D_tnew(D_tnew),
    .E_instr(E_instr), .E_pc(E_pc), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .E_ext(E_ext), .E_a3(E_a3), .E_tnew(E_tnew), .E_valid(E_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] ext,
                         input logic [4:0] a3, input logic [1:0] tnew, input logic valid);
    chk({tag, ".instr"}, E_instr, instr);
    chk({tag, ".pc"}, E_pc, pc);
    chk({tag, ".rs"}, E_rs_data, rs);
    chk({tag, ".rt"}, E_rt_data, rt);
    chk({tag, ".ext"}, E_ext, ext);
    chk({tag, ".a3"}, {27'd0, E_a3}, {27'd0, a3});
    chk({tag, ".tnew"}, {30'd0, E_tnew}, {30'd0, tnew});
    chk({tag, ".valid"}, {31'd0, E_valid}, {31'd0, valid});
  endtask
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ext, input logic [4:0] a3,
                       input logic [1:0] tnew);
    D_instr = instr; D_pc = pc; D_rs_data = rs; D_rt_data = rt; D_ext = ext; D_a3 = a3; D_tnew = tnew;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; en = 1'b1; clr = 1'b0;
    drive(32'hdead_beef, 32'h0000_9999, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd7, 2'd3);
    step;
    chk_all("reset", 32'h0, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    reset = 1'b0;
    drive(32'h3c01_1234, 32'h0000_3004, 32'h0000_00aa, 32'h0000_00bb, 32'h1234_0000, 5'd1, 2'd2);
    step;
    chk_all("load_lui", 32'h3c01_1234, 32'h0000_3004, 32'h0000_00aa, 32'h0000_00bb, 32'h1234_0000, 5'd1, 2'd1, 1'b1);
    drive(32'h0022_1821, 32'h0000_3008, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 5'd3, 2'd0);
    step;
    chk_all("tnew0_sat", 32'h0022_1821, 32'h0000_3008, 32'h0000_0005, 32'h0000_0006, 32'h0, 5'd3, 2'd0, 1'b1);
    drive(32'h8c24_0010, 32'h0000_300c, 32'hcafe_0000, 32'h0000_beef, 32'h0000_0010, 5'd4, 2'd3);
    step;
    chk_all("tnew3", 32'h8c24_0010, 32'h0000_300c, 32'hcafe_0000, 32'h0000_beef, 32'h0000_0010, 5'd4, 2'd2, 1'b1);
    drive(32'h3425_ffff, 32'h0000_3010, 32'h0000_0001, 32'h0000_0002, 32'h0000_ffff, 5'd5, 2'd1);
    step;
    chk_all("tnew1", 32'h3425_ffff, 32'h0000_3010, 32'h0000_0001, 32'h0000_0002, 32'h0000_ffff, 5'd5, 2'd0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom));
      step;
      chk_all("hold", 32'h3425_ffff, 32'h0000_3010, 32'h0000_0001, 32'h0000_0002, 32'h0000_ffff, 5'd5, 2'd0, 1'b1);
    end
    clr = 1'b1;
    drive(32'h1234_5678, 32'h0000_3008, 32'h0000_0077, 32'h0000_0088, 32'h0000_0099, 5'd9, 2'd2);
    step;
    chk_all("clr_stall", 32'h0, 32'h0000_3008, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    clr = 1'b0;
    drive(32'h1111_2222, 32'h0000_4000, 32'h1, 32'h2, 32'h3, 5'd10, 2'd2);
    step;
    chk_all("hold_bubble", 32'h0, 32'h0000_3008, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    en = 1'b1; clr = 1'b1;
    drive(32'h2222_3333, 32'h0000_4004, 32'h4, 32'h5, 32'h6, 5'd11, 2'd3);
    step;
    chk_all("clr_en", 32'h0, 32'h0000_4004, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    clr = 1'b0;
    drive(32'h0041_2020, 32'h0000_4008, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 5'd31, 2'd2);
    step;
    chk_all("reload", 32'h0041_2020, 32'h0000_4008, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 5'd31, 2'd1, 1'b1);
    reset = 1'b1; clr = 1'b1; en = 1'b1;
    drive(32'h5555_5555, 32'h0000_400c, 32'h7, 32'h8, 32'h9, 5'd12, 2'd3);
    step;
    chk_all("rst_clr_en", 32'h0, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    reset = 1'b0; clr = 1'b0;
    drive(32'h6666_6666, 32'h0000_5000, 32'ha, 32'hb, 32'hc, 5'd13, 2'd2);
    step;
    reset = 1'b1; en = 1'b0;
    step;
    chk_all("rst_hold", 32'h0, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
